// File: rtl/fetch_pc_rv32i.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fetch_pc_rv32i                                                  |
// | Purpose  : PC register and single-outstanding instruction-fetch sequencer. |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module fetch_pc_rv32i #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned WAIT_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic        pc_update,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_new,
  output logic        instr_valid,
  output logic        fetch_err,
  output logic [31:0] instret
);

  localparam logic [2:0]  c_st_boot  = 3'd0;
  localparam logic [2:0]  c_st_req   = 3'd1;
  localparam logic [2:0]  c_st_wait  = 3'd2;
  localparam logic [2:0]  c_st_valid = 3'd3;
  localparam logic [2:0]  c_st_err   = 3'd4;
  localparam logic [31:0] c_nop      = 32'h0000_0013;
  // The terminal count is checked before incrementing, so the last legal value is one less.
  localparam logic [15:0] c_tmo_last = 16'(WAIT_TIMEOUT - 1);

  logic [2:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_instr_pc;
  logic [31:0] r_instret;
  logic [15:0] r_tmo;

  logic w_tmo_hit;
  logic w_misaligned;
  logic w_req_done;

  assign w_tmo_hit    = (r_tmo == c_tmo_last);
  assign w_misaligned = |pc_in[1:0];
  assign w_req_done   = imem_gnt & imem_rvalid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= c_st_boot;
      r_pc       <= RESET_PC;
      r_instr    <= c_nop;
      r_instr_pc <= RESET_PC;
      r_instret  <= 32'd0;
      r_tmo      <= 16'd0;
    end else begin
      case (r_state)
        c_st_boot: begin
          r_state <= c_st_req;
          r_tmo   <= 16'd0;
        end
        c_st_req: begin
          if (w_req_done) begin
            r_instr    <= imem_rdata;
            r_instr_pc <= r_pc;
            r_state    <= c_st_valid;
          end else if (w_tmo_hit) begin
            r_state <= c_st_err;
          end else begin
            r_tmo <= r_tmo + 16'd1;
            if (imem_gnt) r_state <= c_st_wait;
          end
        end
        c_st_wait: begin
          if (imem_rvalid) begin
            r_instr    <= imem_rdata;
            r_instr_pc <= r_pc;
            r_state    <= c_st_valid;
          end else if (w_tmo_hit) begin
            r_state <= c_st_err;
          end else begin
            r_tmo <= r_tmo + 16'd1;
          end
        end
        c_st_valid: begin
          if (pc_update) begin
            r_instret <= r_instret + 32'd1;
            r_pc      <= pc_in;
            r_tmo     <= 16'd0;
            r_state   <= w_misaligned ? c_st_err : c_st_req;
          end
        end
        c_st_err: begin
          r_state <= c_st_err;
        end
        default: begin
          r_state <= c_st_boot;
        end
      endcase
    end
  end

  assign imem_req    = (r_state == c_st_req);
  assign imem_addr   = r_pc;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign pc_new      = r_instr_pc + 32'd4;
  assign instr_valid = (r_state == c_st_valid);
  assign fetch_err   = (r_state == c_st_err);
  assign instret     = r_instret;

endmodule
`default_nettype wire

// File: doc/fetch_pc_rv32i.md
Name: fetch_pc_rv32i

Overview:
Program-counter register and instruction-fetch sequencer for the single-cycle RV32I core. Holds the architectural PC and issues word fetches to instruction memory over a req/gnt/rvalid handshake. Presents the fetched instruction and its PC to decode, and drives PC+4 into the branch-resolution stage. Loads that stage's selected next-PC when the core retires the current instruction.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
WAIT_TIMEOUT, 16, max cycles in REQ or WAIT before a fetch error is flagged; range 2..65535.

Ports:
clk  input  1  core clock, rising edge.
rst  input  1  asynchronous, active-high reset.
pc_in  input  32  next PC selected by the branch stage (PC+4 or branch target).
pc_update  input  1  core retires the presented instruction; PC loads pc_in.
imem_req  output  1  fetch request valid.
imem_addr  output  32  fetch byte address (= current PC).
imem_gnt  input  1  memory accepted the request this cycle.
imem_rvalid  input  1  imem_rdata is valid this cycle.
imem_rdata  input  32  fetched instruction word.
instr  output  32  instruction held for decode.
instr_pc  output  32  PC of instr.
pc_new  output  32  instr_pc + 4, to the branch stage.
instr_valid  output  1  instr/instr_pc are valid.
fetch_err  output  1  sticky: misaligned pc_in or handshake timeout.
instret  output  32  retired-instruction counter.

Behaviour:
- Reset (async assert, sync release): state=BOOT, pc=RESET_PC, instr=32'h0000_0013 (NOP), instr_valid=0, imem_req=0, fetch_err=0, instret=0, timeout counter=0.
- BOOT: one cycle, no request -> REQ.
- REQ: imem_req=1, imem_addr=pc held stable until gnt. gnt&rvalid same cycle -> latch rdata, VALID. gnt only -> WAIT. Neither -> stay.
- WAIT: imem_req=0. rvalid -> latch rdata into instr, VALID. rvalid outside WAIT (or the REQ-with-gnt case) is ignored.
- VALID: instr_valid=1. instr/instr_pc are stable until pc_update. On pc_update: instret+=1 (wraps at 2^32); pc<=pc_in; if pc_in[1:0]!=0 -> ERR, otherwise -> REQ. pc_update in any other state is ignored; instret is unchanged.
- ERR: terminal until reset. fetch_err=1, instr_valid=0, imem_req=0.
- Timeout: counter clears on entering REQ and increments each cycle in REQ or WAIT. When it reaches WAIT_TIMEOUT with no completion -> ERR.
- Fetch latency: REQ->VALID minimum 1 cycle (gnt&rvalid in REQ), so instr_valid is asserted the cycle after completion.
- pc_new = instr_pc + 4, combinational, 32-bit modulo (0xFFFF_FFFC -> 0x0000_0000).
- instr_pc updates with instr on fetch completion, not on pc load.
- Reset asserted mid-WAIT: outstanding response is dropped. An rvalid arriving after reset release, before the first grant, is ignored.
- No speculative or overlapping fetches: at most one request outstanding.

Test Plan:
- Reset with RESET_PC=0x100, mem gnt+rvalid same cycle with rdata=0x00500093 -> imem_addr=0x100 in REQ, instr_valid on cycle 3, instr=0x00500093, pc_new=0x104.
- Sequential retire: pc_update with pc_in=0x104, memory 2-cycle rvalid latency -> imem_addr=0x104, instr_valid after gnt+2, instret=1.
- Taken branch: in VALID, pc_update with pc_in=0x40 -> next imem_addr=0x40, instr_pc=0x40 after fetch, instret increments once.
- Misaligned target: pc_update with pc_in=0x42 -> ERR, fetch_err=1, imem_req stays 0; pc_update ignored until rst.
- Timeout: WAIT_TIMEOUT=4, gnt never asserted -> fetch_err=1 after 4 cycles in REQ. Separately, gnt but no rvalid -> fetch_err=1 after the combined count reaches 4.
- Wrap and async reset: instr_pc=0xFFFFFFFC -> pc_new=0x0. Assert rst mid-WAIT then deliver a stale rvalid -> it is ignored, BOOT->REQ at RESET_PC, instret=0.
